lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl.sv | 149 ++++++++++++++
 tb/tb_lcd_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780-style 16x2 character LCD controller: power-on wait, five-command
// init sequence, then character writes with cursor tracking, line wrap and clear.
module lcd_ctrl #(
  parameter int PWR_WAIT = 750000,
  parameter int CMD_WAIT = 2000,
  parameter int CLR_WAIT = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       clr_req,
  output logic       init_done,
  output logic       wr_enable,
  input  logic       wr_finish,
  output logic       reg_sel,
  output logic [7:0] data_out,
  output logic       cur_line,
  output logic [3:0] cur_col
);

  localparam int MAX_WAIT = (PWR_WAIT > CMD_WAIT) ?
                            ((PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT) :
                            ((CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT);
  localparam int CW = ($clog2(MAX_WAIT + 1) > 17) ? $clog2(MAX_WAIT + 1) : 17;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {ST_PWR_WAIT, ST_ISSUE, ST_BUSY, ST_DELAY, ST_IDLE} state_t;
  // What the write in flight was for; decides where DELAY goes next.
  typedef enum logic [1:0] {OP_INIT, OP_CHAR, OP_ADDR, OP_CLR} op_t;

  state_t        st;
  op_t           op;
  logic [CW-1:0] cnt;
  logic [2:0]    init_idx;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      3'd3:    return 8'h06;
      default: return 8'h80;
    endcase
  endfunction

  assign char_ready = (st == ST_IDLE) && init_done && !clr_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_PWR_WAIT;
      op        <= OP_INIT;
      cnt       <= '0;
      init_idx  <= 3'd0;
      wr_enable <= 1'b0;
      reg_sel   <= 1'b0;
      data_out  <= 8'h00;
      init_done <= 1'b0;
      cur_line  <= 1'b0;
      cur_col   <= 4'd0;
    end else begin
      case (st)
        ST_PWR_WAIT: begin
          if (cnt == CW'(PWR_WAIT)) begin
            st        <= ST_ISSUE;
            op        <= OP_INIT;
            init_idx  <= 3'd0;
            reg_sel   <= 1'b0;
            data_out  <= init_cmd(3'd0);
            wr_enable <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_ISSUE: begin
          wr_enable <= 1'b0;
          st        <= ST_BUSY;
        end
        ST_BUSY: begin
          if (wr_finish) begin
            st  <= ST_DELAY;
            cnt <= (!reg_sel && data_out == 8'h01) ? CW'(CLR_WAIT) : CW'(CMD_WAIT);
          end
        end
        ST_DELAY: begin
          if (cnt <= CNT_ONE) begin
            case (op)
              OP_INIT: begin
                if (init_idx == 3'd4) begin
                  init_done <= 1'b1;
                  cur_line  <= 1'b0;
                  cur_col   <= 4'd0;
                  st        <= ST_IDLE;
                end else begin
                  init_idx  <= init_idx + 3'd1;
                  reg_sel   <= 1'b0;
                  data_out  <= init_cmd(init_idx + 3'd1);
                  wr_enable <= 1'b1;
                  st        <= ST_ISSUE;
                end
              end
              OP_CHAR: begin
                // Past the last column: wrap and move the LCD address to the other line.
                if (cur_col == 4'd15) begin
                  cur_col   <= 4'd0;
                  cur_line  <= ~cur_line;
                  reg_sel   <= 1'b0;
                  data_out  <= cur_line ? 8'h80 : 8'hC0;
                  wr_enable <= 1'b1;
                  op        <= OP_ADDR;
                  st        <= ST_ISSUE;
                end else begin
                  cur_col <= cur_col + 4'd1;
                  st      <= ST_IDLE;
                end
              end
              OP_CLR: begin
                cur_line <= 1'b0;
                cur_col  <= 4'd0;
                st       <= ST_IDLE;
              end
              default: st <= ST_IDLE;
            endcase
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            reg_sel   <= 1'b0;
            data_out  <= 8'h01;
            wr_enable <= 1'b1;
            op        <= OP_CLR;
            st        <= ST_ISSUE;
          end else if (char_valid && char_ready) begin
            reg_sel   <= 1'b1;
            data_out  <= char_data;
            wr_enable <= 1'b1;
            op        <= OP_CHAR;
            st        <= ST_ISSUE;
          end
        end
        default: st <= ST_PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short waits and a write engine that
// answers each wr_enable with wr_finish three cycles later.
module tb_lcd_ctrl;
  localparam int PW = 10;
  localparam int CMDW = 4;
  localparam int CLRW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       clr_req = 1'b0;
  logic       spur = 1'b0;
  logic       char_ready, init_done, wr_enable, wr_finish, reg_sel, cur_line;
  logic [7:0] data_out;
  logic [3:0] cur_col;
  logic [3:0] fin_pipe = 4'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [8:0] log_q[$];
  int         tcyc_q[$];

  lcd_ctrl #(.PWR_WAIT(PW), .CMD_WAIT(CMDW), .CLR_WAIT(CLRW)) dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .clr_req(clr_req), .init_done(init_done),
    .wr_enable(wr_enable), .wr_finish(wr_finish), .reg_sel(reg_sel),
    .data_out(data_out), .cur_line(cur_line), .cur_col(cur_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model and bus-write log, both sampled on the falling edge.
  always @(negedge clk) begin
    fin_pipe <= {fin_pipe[2:0], wr_enable};
    if (wr_enable) begin
      log_q.push_back({reg_sel, data_out});
      tcyc_q.push_back(cyc);
    end
  end
  assign wr_finish = fin_pipe[3] | spur;

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!char_ready && n < 300) begin
      tick;
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 300), 32'd1);
  endtask

  task automatic send_char(input logic [7:0] c, output int acc);
    int n = 0;
    char_data  = c;
    char_valid = 1'b1;
    while (!char_ready && n < 300) begin
      tick;
      n++;
    end
    check("chr_ready_timeout", 32'(n < 300), 32'd1);
    acc = cyc + 1;
    tick;
    char_valid = 1'b0;
    check("chr_wr_latency", 32'(wr_enable), 32'd1);
    check("chr_word", 32'(log_q[$]), {23'd0, 1'b1, c});
  endtask

  initial begin
    int rel, acc, base, n, wr_t;
    logic [8:0] init_exp[5];
    int gap_exp[4];
    init_exp = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    gap_exp  = '{8, 8, 12, 8};

    repeat (3) tick;
    check("rst_wr_enable", 32'(wr_enable), 32'd0);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_char_ready", 32'(char_ready), 32'd0);

    // Power-on wait and init sequence.
    rst = 1'b0;
    rel = cyc;
    n = 0;
    while (!init_done && n < 400) begin
      tick;
      n++;
    end
    check("init_timeout", 32'(n < 400), 32'd1);
    check("init_nwrites", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("init_cmd", 32'(log_q[i]), 32'(init_exp[i]));
    check("pwr_wait_latency", 32'(tcyc_q[0] - rel), 32'd11);
    for (int i = 1; i < 5; i++) check("init_gap", 32'(tcyc_q[i] - tcyc_q[i-1]), 32'(gap_exp[i-1]));
    check("init_done_latency", 32'(cyc - tcyc_q[4]), 32'd8);
    check("init_cursor", {27'd0, cur_line, cur_col}, 32'd0);
    check("idle_char_ready", 32'(char_ready), 32'd1);

    // Spurious wr_finish in IDLE.
    spur = 1'b1;
    tick;
    spur = 1'b0;
    repeat (4) tick;
    check("spur_idle_nwrites", 32'(log_q.size()), 32'd5);
    check("spur_idle_ready", 32'(char_ready), 32'd1);

    // Single character, with a spurious wr_finish during its DELAY.
    send_char(8'h41, acc);
    repeat (4) tick;
    spur = 1'b1;
    tick;
    spur = 1'b0;
    wait_idle("chr41_idle");
    check("chr41_duration", 32'(cyc - acc), 32'd8);
    check("chr41_cursor", {27'd0, cur_line, cur_col}, 32'd1);
    check("spur_delay_nwrites", 32'(log_q.size()), 32'd6);

    // Clear and character requested together: clear goes first.
    char_data  = 8'h5A;
    char_valid = 1'b1;
    clr_req    = 1'b1;
    #1;
    check("clr_blocks_ready", 32'(char_ready), 32'd0);
    tick;
    clr_req = 1'b0;
    wr_t = cyc;
    check("clr_wr_enable", 32'(wr_enable), 32'd1);
    check("clr_word", 32'(log_q[$]), 32'h001);
    tick;
    check("clr_busy_ready", 32'(char_ready), 32'd0);
    wait_idle("clr_idle");
    check("clr_duration", 32'(cyc - wr_t), 32'd12);
    check("clr_cursor", {27'd0, cur_line, cur_col}, 32'd0);
    tick;
    char_valid = 1'b0;
    check("held_chr_wr", 32'(wr_enable), 32'd1);
    check("held_chr_word", 32'(log_q[$]), 32'h15A);
    wait_idle("held_chr_idle");
    check("held_chr_cursor", {27'd0, cur_line, cur_col}, 32'd1);

    // Plain clear back to home.
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    check("clr2_word", 32'(log_q[$]), 32'h001);
    wait_idle("clr2_idle");
    check("clr2_cursor", {27'd0, cur_line, cur_col}, 32'd0);

    // 32 characters: wrap to line 1 after 16, back to line 0 after 32.
    base = log_q.size();
    for (int i = 1; i <= 32; i++) begin
      send_char(8'h20 + 8'(i), acc);
      wait_idle("run_idle");
      check("run_col", 32'(cur_col), 32'(i % 16));
      check("run_line", 32'(cur_line), 32'((i >= 16 && i < 32) ? 1 : 0));
      if (i % 16 == 0) check("run_addr_word", 32'(log_q[$]), (i == 16) ? 32'h0C0 : 32'h080);
    end
    check("run_nwrites", 32'(log_q.size() - base), 32'd34);
    check("run_17th_write", 32'(log_q[base + 16]), 32'h0C0);

    // Reset while BUSY.
    send_char(8'h55, acc);
    tick;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_wr_enable", 32'(wr_enable), 32'd0);
    check("mid_rst_reg_sel", 32'(reg_sel), 32'd0);
    check("mid_rst_data_out", 32'(data_out), 32'h00);
    check("mid_rst_init_done", 32'(init_done), 32'd0);
    check("mid_rst_char_ready", 32'(char_ready), 32'd0);
    tick;
    tick;
    rst = 1'b0;
    rel = cyc;
    base = log_q.size();
    n = 0;
    while (log_q.size() == base && n < 100) begin
      tick;
      n++;
    end
    check("reinit_timeout", 32'(n < 100), 32'd1);
    check("reinit_latency", 32'(tcyc_q[base] - rel), 32'd11);
    check("reinit_word", 32'(log_q[base]), 32'h038);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
